// File: rtl/rbm_hidden_sched_if.sv
// rtl/rbm_hidden_sched_if.sv - handshake bundle between rbm_hidden_sched and its frame, weight, core and result neighbours
interface rbm_hidden_sched_if #(
  parameter int J_W = 6
);
  logic           frame_valid;
  logic           frame_ready;
  logic           abort;
  logic           col_req;
  logic           col_rdy;
  logic [J_W-1:0] sel_j;
  logic           core_start;
  logic           core_busy;
  logic [15:0]    core_pj;
  logic           h_valid;
  logic           h_ready;
  logic [J_W-1:0] h_idx;
  logic [15:0]    h_data;
  logic           frame_done;
  logic           err;

  modport master (
    input  frame_valid, abort, col_rdy, core_busy, core_pj, h_ready,
    output frame_ready, col_req, sel_j, core_start, h_valid, h_idx, h_data, frame_done, err
  );

  modport slave (
    output frame_valid, abort, col_rdy, core_busy, core_pj, h_ready,
    input  frame_ready, col_req, sel_j, core_start, h_valid, h_idx, h_data, frame_done, err
  );
endinterface

// File: rtl/rbm_hidden_sched.sv
// rtl/rbm_hidden_sched.sv - RBM hidden-layer scheduler; WAIT watchdog and sticky err under RBM_SCHED_TIMEOUT_EN
module rbm_hidden_sched #(
  parameter int I_DIM = 256,
  parameter int H_DIM = 64,
  parameter int J_W   = (H_DIM > 1) ? $clog2(H_DIM) : 1
) (
  input logic                clk,
  input logic                rst,
  rbm_hidden_sched_if.master bus_io
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_START, S_WAIT, S_EMIT, S_NEXT} state_t;

  localparam logic [J_W-1:0] J_LAST = J_W'(H_DIM - 1);

  if (H_DIM < 1 || I_DIM < 1) begin : g_bad_param
    $error("rbm_hidden_sched: H_DIM and I_DIM must be >= 1");
  end

  state_t         state_q, state_d;
  logic [J_W-1:0] j_q, j_d;
  logic [J_W-1:0] h_idx_q, h_idx_d;
  logic [15:0]    h_data_q, h_data_d;
  logic           seen_busy_q, seen_busy_d;

`ifdef RBM_SCHED_TIMEOUT_EN
  localparam int TMO   = I_DIM + 16;
  localparam int CNT_W = $clog2(TMO + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    j_d         = j_q;
    h_idx_d     = h_idx_q;
    h_data_d    = h_data_q;
    seen_busy_d = seen_busy_q;
`ifdef RBM_SCHED_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus_io.frame_valid) begin
          state_d = S_REQ;
          j_d     = '0;
        end
      end
      S_REQ: begin
        if (bus_io.col_rdy) state_d = S_START;
      end
      S_START: begin
        seen_busy_d = 1'b0;
`ifdef RBM_SCHED_TIMEOUT_EN
        cnt_d       = '0;
`endif
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (bus_io.core_busy) seen_busy_d = 1'b1;
        // Completion is the falling edge of busy after it was observed high.
        if (seen_busy_q && !bus_io.core_busy) begin
          h_data_d = bus_io.core_pj;
          h_idx_d  = j_q;
          state_d  = S_EMIT;
        end
`ifdef RBM_SCHED_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TMO) ||
                 (!seen_busy_q && !bus_io.core_busy && cnt_q == CNT_W'(3))) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
        cnt_d = cnt_q + CNT_W'(1);
`endif
      end
      S_EMIT: begin
        if (bus_io.h_ready) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (j_q == J_LAST) begin
          state_d = S_IDLE;
        end else begin
          j_d     = j_q + J_W'(1);
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus_io.abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      j_q         <= '0;
      h_idx_q     <= '0;
      h_data_q    <= '0;
      seen_busy_q <= 1'b0;
`ifdef RBM_SCHED_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      h_idx_q     <= h_idx_d;
      h_data_q    <= h_data_d;
      seen_busy_q <= seen_busy_d;
`ifdef RBM_SCHED_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign bus_io.frame_ready = (state_q == S_IDLE) && !rst;
  assign bus_io.col_req     = (state_q == S_REQ);
  assign bus_io.core_start  = (state_q == S_START);
  assign bus_io.h_valid     = (state_q == S_EMIT);
  assign bus_io.frame_done  = (state_q == S_NEXT) && (j_q == J_LAST);
  assign bus_io.sel_j       = j_q;
  assign bus_io.h_idx       = h_idx_q;
  assign bus_io.h_data      = h_data_q;
`ifdef RBM_SCHED_TIMEOUT_EN
  assign bus_io.err         = err_q;
`else
  assign bus_io.err         = 1'b0;
`endif
endmodule

// File: tb/tb_rbm_hidden_sched.sv
// tb/tb_rbm_hidden_sched.sv - directed self-checking bench for rbm_hidden_sched (RBM_SCHED_TIMEOUT_EN adds the watchdog test)
module tb_rbm_hidden_sched;
  localparam int I_DIM = 8;
  localparam int H_DIM = 4;
  localparam int J_W   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rbm_hidden_sched_if #(.J_W(J_W)) bus ();

  rbm_hidden_sched #(.I_DIM(I_DIM), .H_DIM(H_DIM), .J_W(J_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Core and weight-wrapper responders
  int busy_len = 9;
  int busy_cnt = 0;
  int creq_cnt = 0;
  bit col_delay = 1'b0;
  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) busy_cnt <= 0;
    else if (bus.core_start) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (!bus.col_req) creq_cnt <= 0;
    else creq_cnt <= creq_cnt + 1;
  end

  assign bus.core_busy = (busy_cnt != 0);
  assign bus.core_pj   = 16'h1000 + 16'(bus.sel_j);
  assign bus.col_rdy   = col_delay ? (bus.col_req && creq_cnt == 3) : 1'b1;

  // Output monitor
  logic [J_W-1:0] got_idx[$];
  logic [15:0]    got_data[$];
  int fd_cnt = 0, fd_cyc = 0, cs_cnt = 0, cr_cnt = 0, hv_cnt = 0, sel_bad = 0, bad_start = 0;
  logic prev_rdy = 1'b0, prev_win = 1'b0;
  logic [J_W-1:0] win_sel = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.h_valid && bus.h_ready) begin
        got_idx.push_back(bus.h_idx);
        got_data.push_back(bus.h_data);
      end
      if (bus.h_valid) hv_cnt++;
      if (bus.frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (bus.core_start) begin
        cs_cnt++;
        if (!prev_rdy) bad_start++;
      end
      if (bus.col_req) cr_cnt++;
      if (bus.col_req && !prev_win) win_sel = bus.sel_j;
      else if ((bus.col_req || bus.core_start) && bus.sel_j != win_sel) sel_bad++;
      prev_win = bus.col_req || bus.core_start;
      prev_rdy = bus.col_req && bus.col_rdy;
    end
  end

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_idx.delete();
    got_data.delete();
    fd_cnt = 0; fd_cyc = 0; cs_cnt = 0; cr_cnt = 0; hv_cnt = 0; sel_bad = 0; bad_start = 0;
  endtask

  task automatic start_frame(output int c_set);
    drive_edge();
    bus.frame_valid = 1'b1;
    c_set = cyc;
    drive_edge();
    bus.frame_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      sample();
      if (fd_cnt != 0) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) drive_edge();
    checks++; if (bus.frame_ready !== 1'b0) $display("FAIL rst_frame_ready_in_reset: got %b expected 0", bus.frame_ready); else passed++;
    rst = 1'b0;
    sample();
    checks++; if (bus.frame_ready !== 1'b1) $display("FAIL rst_frame_ready: got %b expected 1", bus.frame_ready); else passed++;
    checks++;
    if ({bus.col_req, bus.core_start, bus.h_valid, bus.frame_done, bus.err} !== 5'b0)
      $display("FAIL rst_ctrl: got req/start/hv/fd/err=%b expected 00000",
               {bus.col_req, bus.core_start, bus.h_valid, bus.frame_done, bus.err});
    else passed++;
    checks++;
    if (bus.sel_j !== '0 || bus.h_idx !== '0 || bus.h_data !== 16'h0)
      $display("FAIL rst_data: got sel_j=%0d h_idx=%0d h_data=%h expected 0/0/0000", bus.sel_j, bus.h_idx, bus.h_data);
    else passed++;
  endtask

  task automatic test_basic();
    int c_set;
    bit seen;
    clear_mon();
    col_delay = 1'b0; bus.h_ready = 1'b1; busy_len = 9;
    start_frame(c_set);
    wait_done(300, seen);
    checks++; if (!seen) $display("FAIL basic_done: got no frame_done in 300 cycles expected one"); else passed++;
    checks++; if (fd_cyc - c_set !== 56) $display("FAIL basic_cycles: got %0d expected 56", fd_cyc - c_set); else passed++;
    sample();
    checks++; if (bus.frame_ready !== 1'b1) $display("FAIL basic_ready_after: got %b expected 1", bus.frame_ready); else passed++;
    checks++; if (fd_cnt !== 1 || got_idx.size() !== 4) $display("FAIL basic_counts: got fd=%0d results=%0d expected 1/4", fd_cnt, got_idx.size()); else passed++;
    for (int j = 0; j < H_DIM; j++) begin
      checks++;
      if (j >= got_idx.size() || got_idx[j] !== J_W'(j) || got_data[j] !== 16'h1000 + 16'(j))
        $display("FAIL basic_result[%0d]: got idx=%0d data=%h (n=%0d) expected idx=%0d data=%h",
                 j, got_idx[j], got_data[j], got_idx.size(), j, 16'h1000 + 16'(j));
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    int c_set, cs0;
    bit seen;
    clear_mon();
    bus.h_ready = 1'b1;
    start_frame(c_set);
    for (int k = 0; k < 200 && !(bus.col_req && bus.sel_j == 2); k++) sample();
    drive_edge();
    bus.h_ready = 1'b0;
    for (int k = 0; k < 200 && !bus.h_valid; k++) sample();
    cs0 = cs_cnt;
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (bus.h_valid !== 1'b1 || bus.h_idx !== 2'd2 || bus.h_data !== 16'h1002)
        $display("FAIL bp_hold[%0d]: got hv=%b idx=%0d data=%h expected 1/2/1002", n, bus.h_valid, bus.h_idx, bus.h_data);
      else passed++;
      sample();
    end
    checks++; if (cs_cnt !== cs0) $display("FAIL bp_no_start: got %0d starts during stall expected 0", cs_cnt - cs0); else passed++;
    drive_edge();
    bus.h_ready = 1'b1;
    wait_done(300, seen);
    checks++; if (!seen || fd_cnt !== 1) $display("FAIL bp_done: got fd=%0d expected 1", fd_cnt); else passed++;
    for (int j = 0; j < H_DIM; j++) begin
      checks++;
      if (j >= got_idx.size() || got_idx[j] !== J_W'(j) || got_data[j] !== 16'h1000 + 16'(j))
        $display("FAIL bp_result[%0d]: got idx=%0d data=%h (n=%0d) expected idx=%0d data=%h",
                 j, got_idx[j], got_data[j], got_idx.size(), j, 16'h1000 + 16'(j));
      else passed++;
    end
  endtask

  task automatic test_col_delay();
    int c_set;
    bit seen;
    clear_mon();
    col_delay = 1'b1; bus.h_ready = 1'b1;
    start_frame(c_set);
    wait_done(400, seen);
    checks++; if (!seen || fd_cyc - c_set !== 68) $display("FAIL cd_cycles: got %0d expected 68", fd_cyc - c_set); else passed++;
    checks++; if (cr_cnt !== 16) $display("FAIL cd_req_cycles: got %0d expected 16", cr_cnt); else passed++;
    checks++; if (cs_cnt !== 4 || bad_start !== 0) $display("FAIL cd_starts: got %0d starts, %0d early expected 4/0", cs_cnt, bad_start); else passed++;
    checks++; if (sel_bad !== 0) $display("FAIL cd_sel_stable: got %0d changes expected 0", sel_bad); else passed++;
    for (int j = 0; j < H_DIM; j++) begin
      checks++;
      if (j >= got_idx.size() || got_idx[j] !== J_W'(j) || got_data[j] !== 16'h1000 + 16'(j))
        $display("FAIL cd_result[%0d]: got idx=%0d data=%h (n=%0d) expected idx=%0d data=%h",
                 j, got_idx[j], got_data[j], got_idx.size(), j, 16'h1000 + 16'(j));
      else passed++;
    end
    col_delay = 1'b0;
  endtask

  task automatic test_abort();
    int c_set;
    bit seen;
    clear_mon();
    bus.h_ready = 1'b1;
    start_frame(c_set);
    for (int k = 0; k < 200 && !(bus.core_start && bus.sel_j == 1); k++) sample();
    drive_edge();
    bus.abort = 1'b1;
    drive_edge();
    bus.abort = 1'b0;
    checks++;
    if (bus.frame_ready !== 1'b1 || bus.col_req !== 1'b0 || bus.core_start !== 1'b0 || bus.h_valid !== 1'b0)
      $display("FAIL abort_idle: got rdy/req/start/hv=%b expected 1000",
               {bus.frame_ready, bus.col_req, bus.core_start, bus.h_valid});
    else passed++;
    checks++; if (bus.sel_j !== 2'd1) $display("FAIL abort_j_kept: got %0d expected 1", bus.sel_j); else passed++;
    repeat (20) sample();
    checks++; if (fd_cnt !== 0 || got_idx.size() !== 1) $display("FAIL abort_discard: got fd=%0d results=%0d expected 0/1", fd_cnt, got_idx.size()); else passed++;
    clear_mon();
    start_frame(c_set);
    wait_done(300, seen);
    checks++; if (!seen || fd_cnt !== 1) $display("FAIL abort_restart_done: got fd=%0d expected 1", fd_cnt); else passed++;
    for (int j = 0; j < H_DIM; j++) begin
      checks++;
      if (j >= got_idx.size() || got_idx[j] !== J_W'(j) || got_data[j] !== 16'h1000 + 16'(j))
        $display("FAIL abort_result[%0d]: got idx=%0d data=%h (n=%0d) expected idx=%0d data=%h",
                 j, got_idx[j], got_data[j], got_idx.size(), j, 16'h1000 + 16'(j));
      else passed++;
    end
  endtask

  task automatic test_reset_mid_emit();
    int c_set;
    clear_mon();
    bus.h_ready = 1'b1;
    start_frame(c_set);
    for (int k = 0; k < 200 && !(bus.col_req && bus.sel_j == 2); k++) sample();
    drive_edge();
    bus.h_ready = 1'b0;
    for (int k = 0; k < 200 && !bus.h_valid; k++) sample();
    checks++; if (bus.h_valid !== 1'b1 || bus.h_data !== 16'h1002) $display("FAIL rme_pre: got hv=%b data=%h expected 1/1002", bus.h_valid, bus.h_data); else passed++;
    drive_edge();
    rst = 1'b1;
    drive_edge();
    checks++;
    if ({bus.frame_ready, bus.col_req, bus.core_start, bus.h_valid, bus.frame_done, bus.err} !== 6'b0)
      $display("FAIL rme_ctrl: got rdy/req/start/hv/fd/err=%b expected 000000",
               {bus.frame_ready, bus.col_req, bus.core_start, bus.h_valid, bus.frame_done, bus.err});
    else passed++;
    checks++;
    if (bus.sel_j !== '0 || bus.h_idx !== '0 || bus.h_data !== 16'h0)
      $display("FAIL rme_data: got sel_j=%0d h_idx=%0d h_data=%h expected 0/0/0000", bus.sel_j, bus.h_idx, bus.h_data);
    else passed++;
    rst = 1'b0;
    bus.h_ready = 1'b1;
    sample();
    checks++; if (bus.frame_ready !== 1'b1) $display("FAIL rme_ready: got %b expected 1", bus.frame_ready); else passed++;
  endtask

`ifdef RBM_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int c_set, k_err;
    clear_mon();
    busy_len = 40; bus.h_ready = 1'b1;
    start_frame(c_set);
    for (int k = 0; k < 50 && !bus.core_start; k++) sample();
    k_err = 0;
    for (int k = 1; k <= 40; k++) begin
      sample();
      if (bus.err) begin
        k_err = k;
        break;
      end
    end
    checks++; if (k_err !== 26) $display("FAIL tmo_err_cycle: got %0d expected 26", k_err); else passed++;
    checks++; if (bus.frame_ready !== 1'b1) $display("FAIL tmo_idle: got %b expected 1", bus.frame_ready); else passed++;
    checks++; if (hv_cnt !== 0 || fd_cnt !== 0) $display("FAIL tmo_no_result: got hv=%0d fd=%0d expected 0/0", hv_cnt, fd_cnt); else passed++;
    repeat (5) sample();
    checks++; if (bus.err !== 1'b1) $display("FAIL tmo_sticky: got %b expected 1", bus.err); else passed++;
    repeat (20) sample();
    drive_edge();
    rst = 1'b1;
    drive_edge();
    rst = 1'b0;
    busy_len = 9;
    checks++; if (bus.err !== 1'b0) $display("FAIL tmo_clear: got %b expected 0", bus.err); else passed++;
  endtask
`endif

  initial begin
    bus.frame_valid = 1'b0;
    bus.abort       = 1'b0;
    bus.h_ready     = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_col_delay();
    test_abort();
    test_reset_mid_emit();
`ifdef RBM_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/rbm_hidden_sched.md
# rbm_hidden_sched

Hidden-layer scheduler for the RBM forward pass. Accepts one visible frame at a time and walks hidden index j from 0 to H_DIM-1. For each j it requests the weight column and bias, fires the single-hidden GEMV+sigmoid core, and collects its Q0.16 result. Each result is emitted on a ready/valid stream tagged with j. The block sits between the frame-buffer/weight wrapper and the core, and owns the core's start/busy handshake.

## Interface
- I_DIM, 256: visible length; sizes the watchdog limit only.
- H_DIM, 64: number of hidden units per frame; must be ≥1.
- J_W, $clog2(H_DIM) (min 1): width of the hidden index.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- frame_valid  in  1  a visible frame is loaded and stable.
- frame_ready  out  1  scheduler idle; the frame is accepted on frame_valid && frame_ready.
- abort  in  1  synchronous cancel of the current frame.
- col_req  out  1  request the weight column and bias for sel_j.
- col_rdy  in  1  w_col/b_j for sel_j are stable on the core inputs.
- sel_j  out  J_W  hidden index currently being served.
- core_start  out  1  one-cycle start pulse to the core.
- core_busy  in  1  core busy.
- core_pj  in  16  core result, Q0.16.
- h_valid  out  1  result valid.
- h_ready  in  1  downstream accepts the result.
- h_idx  out  J_W  hidden index of h_data.
- h_data  out  16  captured result, Q0.16.
- frame_done  out  1  one-cycle pulse after the last result is accepted.
- err  out  1  sticky watchdog error; see Configuration.

## Operation
- States:
  - IDLE
  - REQ: col_req=1 until col_rdy.
  - START: core_start=1 for exactly one cycle.
  - WAIT: wait for the core to finish.
  - EMIT: h_valid=1 until h_ready.
  - NEXT
- Transitions:
  - IDLE→REQ on frame accept; j←0.
  - REQ→START when col_rdy is sampled high.
  - START→WAIT unconditionally.
  - WAIT: set seen_busy when core_busy=1. When seen_busy && !core_busy, capture core_pj into h_data and j into h_idx, then go to EMIT.
  - EMIT→NEXT on h_valid && h_ready.
  - NEXT: if j==H_DIM-1, pulse frame_done and go to IDLE; else j←j+1 and go to REQ.
- frame_ready = (state==IDLE) && !rst.
- sel_j holds j in every non-IDLE state and is stable throughout REQ, START and WAIT.
- h_data/h_idx hold constant while h_valid && !h_ready.
- abort in any state: next state IDLE. h_valid, col_req and core_start go to 0 on the next edge. j is not reset until the next accept. No frame_done is issued. An in-flight core run completes harmlessly and its result is discarded. abort has priority over every other transition.
- core_busy already high at frame accept is a protocol violation; behaviour is undefined. The bench must not drive it.
- Reset values:
  - state IDLE
  - frame_ready 1 (after reset release)
  - col_req, core_start, h_valid, frame_done, err: 0
  - sel_j, h_idx, h_data: 0

## Timing
- Minimum per-hidden cost, with col_rdy same-cycle, h_ready tied high and core run time T (busy-high cycles): REQ 1 + START 1 + WAIT (T+1) + EMIT 1 + NEXT 1.
- For the core's I_DIM+1 busy cycles, the per-hidden cost is I_DIM+6 cycles.
- frame_done asserts on the cycle after the final EMIT handshake. frame_ready rises on the following cycle.
- The frame input must stay valid from accept until frame_done; the scheduler does not copy it.

## Configuration
- RBM_SCHED_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - If WAIT lasts more than I_DIM+16 cycles, or busy never rises within 4 cycles of START, then err←1 (sticky until rst) and the state goes to IDLE with no result and no frame_done.
- RBM_SCHED_TIMEOUT_EN undefined:
  - WAIT waits forever.
  - err is tied 0.
  - No counter logic is present.

## Test plan
- H_DIM=4, I_DIM=8, core model busy 9 cycles returning 16'h1000+j, col_rdy=1, h_ready=1: four results with h_idx 0..3 and h_data 1000..1003; frame_done once; cycle count matches Timing.
- h_ready low for 5 cycles during j=2: h_valid stays high; h_idx=2 and h_data stay stable; no further core_start until the handshake.
- col_rdy delayed 3 cycles per column: col_req high for 4 cycles per j; core_start only after col_rdy; sel_j stable throughout.
- abort asserted in WAIT of j=1: the next cycle is IDLE with frame_ready=1; no frame_done; a new frame then restarts at j=0 with correct results.
- With RBM_SCHED_TIMEOUT_EN, core holds busy for 40 cycles with I_DIM=8: err=1 at WAIT cycle 25, return to IDLE, no h_valid for that j.
- rst pulsed mid-EMIT: all outputs return to their reset values on the next edge; frame_ready=1 after release.
